// File: rtl/al_mult_acc_pkg.sv
// Shared constants for the multiplier accumulator stage: operand format
// encodings and the deepest multiplier pipeline the tag line must track.
package al_mult_acc_pkg;

  localparam int FMT_SIGNED       = 0;
  localparam int FMT_UNSIGNED     = 1;
  localparam int MAX_MULT_LATENCY = 2;

endpackage

// File: rtl/al_tag_delay.sv
// Shift register carrying {valid, last} tags alongside the multiplier pipeline.
// A depth of zero degenerates to a wire.
module al_tag_delay #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [1:0] d,
  output logic [1:0] q
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, rst, clr};
      assign q = d;
    end else begin : g_shift
      logic [1:0] stages [DEPTH];

      always_ff @(posedge clk) begin
        if (rst || clr) begin
          for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else begin
          stages[0] <= d;
          for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
      end

      assign q = stages[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/al_mult_acc.sv
// Group accumulator behind AL_LOGIC_MULT: sums tagged products, optionally
// saturating, and hands each group sum out through a valid/ready register.
module al_mult_acc
  import al_mult_acc_pkg::*;
#(
  parameter int    PROD_WIDTH   = 36,
  parameter int    ACC_WIDTH    = 48,
  parameter int    MULT_LATENCY = 2,
  parameter string INPUTFORMAT  = "SIGNED",
  parameter int    SATURATE     = 1,
  parameter int    CNT_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic                  clr,
  input  logic [PROD_WIDTH-1:0] p,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic [CNT_WIDTH-1:0]  out_cnt,
  output logic                  out_sat,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun
);

  localparam int FMT = (INPUTFORMAT == "UNSIGNED") ? FMT_UNSIGNED : FMT_SIGNED;

  generate
    if (MULT_LATENCY < 0 || MULT_LATENCY > MAX_MULT_LATENCY) begin : g_bad_latency
      $error("al_mult_acc: MULT_LATENCY out of range");
    end
    if (ACC_WIDTH < PROD_WIDTH) begin : g_bad_width
      $error("al_mult_acc: ACC_WIDTH must be at least PROD_WIDTH");
    end
  endgenerate

  logic [1:0] tag_q;
  logic       pv, plast;

  al_tag_delay #(.DEPTH(MULT_LATENCY)) u_tag_delay (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .d   ({in_valid, in_valid & in_last}),
    .q   (tag_q)
  );

  assign pv    = tag_q[1];
  assign plast = tag_q[0];

  logic [ACC_WIDTH-1:0] acc, ext, base, sum_next;
  logic [ACC_WIDTH:0]   sum_wide;
  logic [CNT_WIDTH-1:0] cnt, cnt_next;
  logic                 sat, first, ovf, sat_next, load_req;

  // One extra bit of headroom exposes overflow; the top two bits give the true sign.
  always_comb begin
    ext      = (FMT == FMT_SIGNED) ? ACC_WIDTH'($signed(p)) : ACC_WIDTH'(p);
    base     = first ? '0 : acc;
    sum_wide = '0;
    ovf      = 1'b0;
    if (FMT == FMT_SIGNED) begin
      sum_wide = {base[ACC_WIDTH-1], base} + {ext[ACC_WIDTH-1], ext};
      ovf      = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
    end else begin
      sum_wide = {1'b0, base} + {1'b0, ext};
      ovf      = sum_wide[ACC_WIDTH];
    end
    sum_next = sum_wide[ACC_WIDTH-1:0];
    if (ovf && SATURATE != 0) begin
      if (FMT != FMT_SIGNED)       sum_next = '1;
      else if (sum_wide[ACC_WIDTH]) sum_next = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      else                          sum_next = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
    cnt_next = first ? CNT_WIDTH'(1) : ((&cnt) ? cnt : cnt + CNT_WIDTH'(1));
    sat_next = (first ? 1'b0 : sat) | ovf;
    load_req = pv & plast & ~clr;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc   <= '0;
      cnt   <= '0;
      sat   <= 1'b0;
      first <= 1'b1;
    end else if (pv) begin
      acc   <= sum_next;
      cnt   <= cnt_next;
      sat   <= sat_next;
      first <= plast;
    end
  end

  // A finished group that finds the result register still occupied is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_cnt   <= '0;
      out_sat   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (load_req) begin
        if (!out_valid || out_ready) begin
          out_valid <= 1'b1;
          out_data  <= sum_next;
          out_cnt   <= cnt_next;
          out_sat   <= sat_next;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule
